// File: rtl/vga_sprite_gen.sv
// VGA raster timing plus one scaled, clipped, colour-keyed sprite drawn over a solid background.
// Sprite texels come from an external synchronous RAM that returns data RD_LAT pixel strobes after the address.
module vga_sprite_gen #(
  parameter int          HACT       = 640,
  parameter int          HFP        = 16,
  parameter int          HSYNC      = 96,
  parameter int          HBP        = 48,
  parameter int          VACT       = 480,
  parameter int          VFP        = 10,
  parameter int          VSYNC      = 2,
  parameter int          VBP        = 29,
  parameter int          HS_POL     = 0,
  parameter int          VS_POL     = 0,
  parameter int          SPR_W      = 150,
  parameter int          SPR_H      = 150,
  parameter int          SCALE_LOG2 = 0,
  parameter int          AW         = 15,
  parameter int          RD_LAT     = 1,
  parameter int          KEY_EN     = 1,
  parameter logic [11:0] KEY_COLOR  = 12'hF0F,
  parameter int          FRAME_MOD  = 60
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PIX_EN,
  input  logic [9:0]    SPR_X,
  input  logic [9:0]    SPR_Y,
  input  logic [11:0]   BG_COLOR,
  output logic [AW-1:0] RAM_ADDR,
  input  logic [11:0]   RAM_Q,
  output logic [3:0]    VGA_R,
  output logic [3:0]    VGA_G,
  output logic [3:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic [7:0]    FRAME_CNT,
  output logic          FRAME_START
);

  localparam int HMAX = HACT + HFP + HSYNC + HBP;
  localparam int VMAX = VACT + VFP + VSYNC + VBP;
  localparam int HW   = $clog2(HMAX);
  localparam int VW   = $clog2(VMAX);
  localparam int SW   = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

  localparam logic [10:0]   WIN_W   = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0]   WIN_H   = 11'(SPR_H << SCALE_LOG2);
  localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_LOG2) - 1);
  localparam logic          HS_ON   = (HS_POL != 0);
  localparam logic          VS_ON   = (VS_POL != 0);
  localparam logic          KEY_ON  = (KEY_EN != 0);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [9:0]    sx, sy;
  logic [AW-1:0] row_base, col;
  logic [SW-1:0] hsub, vsub;
  logic [3:0]    dly [RD_LAT+1];
  logic [11:0]   pix_color;

  logic h_last, v_last, frame_wrap, active, in_hwin, in_vwin, win, hs_on, vs_on;
  logic [10:0] h_ext, v_ext;

  assign h_last     = (hcnt == HW'(HMAX - 1));
  assign v_last     = (vcnt == VW'(VMAX - 1));
  assign frame_wrap = h_last && v_last;
  assign active     = (hcnt < HW'(HACT)) && (vcnt < VW'(VACT));
  assign h_ext      = 11'(hcnt);
  assign v_ext      = 11'(vcnt);
  // Window bounds use 11 bits so a sprite near coordinate 1023 does not wrap back to 0.
  assign in_hwin    = (h_ext >= {1'b0, sx}) && (h_ext < ({1'b0, sx} + WIN_W));
  assign in_vwin    = (v_ext >= {1'b0, sy}) && (v_ext < ({1'b0, sy} + WIN_H));
  assign win        = active && in_hwin && in_vwin;
  assign hs_on      = (hcnt >= HW'(HACT + HFP)) && (hcnt < HW'(HACT + HFP + HSYNC));
  assign vs_on      = (vcnt >= VW'(VACT + VFP)) && (vcnt < VW'(VACT + VFP + VSYNC));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hcnt      <= '0;
      vcnt      <= '0;
      sx        <= '0;
      sy        <= '0;
      FRAME_CNT <= '0;
    end else if (PIX_EN) begin
      hcnt <= h_last ? '0 : hcnt + 1'b1;
      if (h_last)
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      if (frame_wrap) begin
        sx        <= SPR_X;
        sy        <= SPR_Y;
        FRAME_CNT <= (FRAME_CNT == 8'(FRAME_MOD - 1)) ? '0 : FRAME_CNT + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      FRAME_START <= 1'b0;
    else
      FRAME_START <= PIX_EN && frame_wrap;
  end

  // Texel address is built incrementally: row_base steps by SPR_W per scaled texel row, col per scaled texel.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RAM_ADDR <= '0;
      row_base <= '0;
      col      <= '0;
      hsub     <= '0;
      vsub     <= '0;
    end else if (PIX_EN) begin
      RAM_ADDR <= row_base + col;
      if (h_last) begin
        col  <= '0;
        hsub <= '0;
      end else if (in_hwin) begin
        if (hsub == SUB_MAX) begin
          col  <= col + 1'b1;
          hsub <= '0;
        end else begin
          hsub <= hsub + 1'b1;
        end
      end
      // Rows count even when every pixel on the line is clipped, so later rows stay correctly addressed.
      if (frame_wrap) begin
        row_base <= '0;
        vsub     <= '0;
      end else if (h_last && in_vwin) begin
        if (vsub == SUB_MAX) begin
          row_base <= row_base + AW'(SPR_W);
          vsub     <= '0;
        end else begin
          vsub <= vsub + 1'b1;
        end
      end
    end
  end

  // Sync and window flags travel alongside the RAM read so they line up with RAM_Q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i <= RD_LAT; i++)
        dly[i] <= '0;
    end else if (PIX_EN) begin
      dly[0] <= {hs_on, vs_on, active, win};
      for (int i = 1; i <= RD_LAT; i++)
        dly[i] <= dly[i-1];
    end
  end

  always_comb begin
    pix_color = BG_COLOR;
    if (!dly[RD_LAT][1])
      pix_color = '0;
    else if (dly[RD_LAT][0] && !(KEY_ON && (RAM_Q == KEY_COLOR)))
      pix_color = RAM_Q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= ~HS_ON;
      VGA_VS <= ~VS_ON;
    end else if (PIX_EN) begin
      VGA_R  <= pix_color[11:8];
      VGA_G  <= pix_color[7:4];
      VGA_B  <= pix_color[3:0];
      VGA_HS <= dly[RD_LAT][3] ? HS_ON : ~HS_ON;
      VGA_VS <= dly[RD_LAT][2] ? VS_ON : ~VS_ON;
    end
  end

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Randomized bench for vga_sprite_gen on a tiny 12x7 raster: two instances (unscaled RD_LAT=1, 2x scaled RD_LAT=2)
// are compared pixel by pixel against a coordinate-based model of the expected picture.
module tb_vga_sprite_gen;

  localparam int HACT = 8, HFP = 1, HSYNC = 2, HBP = 1;
  localparam int VACT = 4, VFP = 1, VSYNC = 1, VBP = 1;
  localparam int HMAX = 12, VMAX = 7, FRAME = HMAX * VMAX;
  localparam int SPR_W = 3, SPR_H = 2, AW = 4, FMOD = 5;
  localparam logic [11:0] KEY = 12'hF0F;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          PIX_EN = 1'b0;
  logic [9:0]    SPR_X = '0, SPR_Y = '0;
  logic [11:0]   BG = '0;

  logic [AW-1:0] addr0, addr1;
  logic [11:0]   q0, q1;
  logic [3:0]    r0, g0, b0, r1, g1, b1;
  logic          hs0, vs0, hs1, vs1, fs0, fs1;
  logic [7:0]    fc0, fc1;

  logic [11:0]   mem [16];
  logic [11:0]   rq0;
  logic [11:0]   rq1 [2];

  int n, compared, mismatched;
  int fsx [64];
  int fsy [64];
  bit fsExp;

  always #5 CLK = ~CLK;

  vga_sprite_gen #(.HACT(HACT), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP), .VACT(VACT), .VFP(VFP),
    .VSYNC(VSYNC), .VBP(VBP), .HS_POL(0), .VS_POL(0), .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(0),
    .AW(AW), .RD_LAT(1), .KEY_EN(1), .KEY_COLOR(KEY), .FRAME_MOD(FMOD)) dut0 (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN), .SPR_X(SPR_X), .SPR_Y(SPR_Y), .BG_COLOR(BG),
    .RAM_ADDR(addr0), .RAM_Q(q0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0),
    .FRAME_CNT(fc0), .FRAME_START(fs0));

  vga_sprite_gen #(.HACT(HACT), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP), .VACT(VACT), .VFP(VFP),
    .VSYNC(VSYNC), .VBP(VBP), .HS_POL(0), .VS_POL(0), .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(1),
    .AW(AW), .RD_LAT(2), .KEY_EN(1), .KEY_COLOR(KEY), .FRAME_MOD(FMOD)) dut1 (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN), .SPR_X(SPR_X), .SPR_Y(SPR_Y), .BG_COLOR(BG),
    .RAM_ADDR(addr1), .RAM_Q(q1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
    .FRAME_CNT(fc1), .FRAME_START(fs1));

  // Synchronous sprite RAMs that only advance on pixel strobes.
  always @(posedge CLK) if (PIX_EN) rq0 <= mem[addr0];
  always @(posedge CLK) if (PIX_EN) begin
    rq1[0] <= mem[addr1];
    rq1[1] <= rq1[0];
  end
  assign q0 = rq0;
  assign q1 = rq1[1];

  function automatic bit inWin(input int p, input int s);
    int hc, vc, f;
    hc = p % HMAX;
    vc = (p / HMAX) % VMAX;
    f  = p / FRAME;
    return (hc < HACT) && (vc < VACT) && (hc >= fsx[f]) && (hc < fsx[f] + (SPR_W << s))
           && (vc >= fsy[f]) && (vc < fsy[f] + (SPR_H << s));
  endfunction

  function automatic int texAddr(input int p, input int s);
    int hc, vc, f;
    hc = p % HMAX;
    vc = (p / HMAX) % VMAX;
    f  = p / FRAME;
    return ((vc - fsy[f]) >> s) * SPR_W + ((hc - fsx[f]) >> s);
  endfunction

  function automatic void expPix(input int p, input int s, output logic [11:0] rgb,
                                 output logic hs, output logic vs);
    int hc, vc;
    logic [11:0] t;
    if (p < 0) begin
      rgb = '0; hs = 1'b1; vs = 1'b1;
      return;
    end
    hc  = p % HMAX;
    vc  = (p / HMAX) % VMAX;
    hs  = !((hc >= HACT + HFP) && (hc < HACT + HFP + HSYNC));
    vs  = !((vc >= VACT + VFP) && (vc < VACT + VFP + VSYNC));
    rgb = BG;
    if (!((hc < HACT) && (vc < VACT)))
      rgb = '0;
    else if (inWin(p, s)) begin
      t = mem[texAddr(p, s)];
      if (t != KEY) rgb = t;
    end
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    compared++;
    if (obs != exp) begin
      mismatched++;
      $display("[TB] FAIL %s at t=%0t strobe=%0d: got %0h, expected %0h", tag, $time, n, obs, exp);
    end
  endtask

  task automatic checkDut(input int s, input int pipe, input logic [11:0] rgb, input logic hs,
                          input logic vs, input logic [7:0] fc, input logic fs, input logic [AW-1:0] addr);
    logic [11:0] eRgb;
    logic eHs, eVs;
    expPix(n - pipe, s, eRgb, eHs, eVs);
    checkOutput($sformatf("rgb_s%0d", s), int'(rgb), int'(eRgb));
    checkOutput($sformatf("hs_s%0d", s), int'(hs), int'(eHs));
    checkOutput($sformatf("vs_s%0d", s), int'(vs), int'(eVs));
    checkOutput($sformatf("fcnt_s%0d", s), int'(fc), (n / FRAME) % FMOD);
    checkOutput($sformatf("fstart_s%0d", s), int'(fs), int'(fsExp));
    if (n > 0 && inWin(n - 1, s))
      checkOutput($sformatf("addr_s%0d", s), int'(addr), texAddr(n - 1, s));
  endtask

  task automatic checkAll();
    checkDut(0, 3, {r0, g0, b0}, hs0, vs0, fc0, fs0, addr0);
    checkDut(1, 4, {r1, g1, b1}, hs1, vs1, fc1, fs1, addr1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rgb0"}, int'({r0, g0, b0}), 0);
    checkOutput({tag, "_rgb1"}, int'({r1, g1, b1}), 0);
    checkOutput({tag, "_sync0"}, int'({hs0, vs0}), 3);
    checkOutput({tag, "_sync1"}, int'({hs1, vs1}), 3);
    checkOutput({tag, "_fc"}, int'({fc0, fc1}), 0);
    checkOutput({tag, "_fs"}, int'({fs0, fs1}), 0);
    checkOutput({tag, "_addr"}, int'({addr0, addr1}), 0);
  endtask

  task automatic resetDut();
    PIX_EN = 1'b0;
    RST    = 1'b1;
    BG     = 12'($urandom);
    for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
    mem[$urandom_range(0, SPR_W * SPR_H - 1)] = KEY;
    n = 0;
    fsExp = 1'b0;
    fsx[0] = 0;
    fsy[0] = 0;
    repeat (2) @(posedge CLK);
    #1;
    checkResetValues("reset");
    RST = 1'b0;
  endtask

  task automatic applyStimulus(input bit en);
    int p;
    PIX_EN = en;
    if ($urandom_range(0, 39) == 0) begin
      SPR_X = 10'($urandom_range(0, 9));
      SPR_Y = 10'($urandom_range(0, 5));
    end
    @(posedge CLK);
    fsExp = 1'b0;
    if (en) begin
      p = n;
      n++;
      if (p % FRAME == FRAME - 1) begin
        fsExp = 1'b1;
        fsx[n / FRAME] = int'(SPR_X);
        fsy[n / FRAME] = int'(SPR_Y);
      end
    end
    #1;
    checkAll();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    resetDut();
    SPR_X = 10'd3;
    SPR_Y = 10'd1;
    for (int i = 0; i < FRAME * 6 + 30; i++) applyStimulus(1'b1);

    PIX_EN = 1'b0;
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    checkResetValues("midreset");
    resetDut();
    for (int i = 0; i < FRAME * 6; i++) applyStimulus(i % 2 == 0);

    resetDut();
    for (int i = 0; i < FRAME * 4; i++) applyStimulus(1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_sprite_gen.md
Name: vga_sprite_gen

Overview:
Parametrised VGA raster engine: timing generator plus one scaled, clipped, colour-keyed sprite fetched from an external synchronous sprite RAM over a solid background. Successor to the fixed 640x480, 150x150, unscaled test pattern generator. Timing, sprite size, scale, RAM latency and sync polarity are all parameters. Sits between the board clock divider / pixel strobe and the VGA DAC pins; the sprite RAM is instantiated outside this block.

Parameters:
HACT, 640, active pixels per line
HFP, 16, horizontal front porch (pixels)
HSYNC, 96, horizontal sync width
HBP, 48, horizontal back porch
VACT, 480, active lines
VFP, 10, vertical front porch (lines)
VSYNC, 2, vertical sync width
VBP, 29, vertical back porch
HS_POL, 0, sync active level for VGA_HS (0 = active low)
VS_POL, 0, sync active level for VGA_VS
SPR_W, 150, sprite width in texels
SPR_H, 150, sprite height in texels
SCALE_LOG2, 0, each texel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels (0..2)
AW, 15, RAM address width; must satisfy 2^AW >= SPR_W*SPR_H
RD_LAT, 1, RAM read latency in PIX_EN strobes
KEY_EN, 1, enable colour-key transparency
KEY_COLOR, 12'hF0F, texel value treated as transparent
FRAME_MOD, 60, FRAME_CNT modulus

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active high
PIX_EN  in  1  pixel strobe; all state advances only on CLK edges with PIX_EN=1
SPR_X  in  10  sprite left edge, pixels
SPR_Y  in  10  sprite top edge, lines
BG_COLOR  in  12  background {R,G,B}
RAM_ADDR  out  AW  sprite RAM read address
RAM_Q  in  12  sprite RAM data {R[11:8],G[7:4],B[3:0]}
VGA_R  out  4  red
VGA_G  out  4  green
VGA_B  out  4  blue
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
FRAME_CNT  out  8  frame counter, 0..FRAME_MOD-1
FRAME_START  out  1  one-CLK pulse when frame wraps (qualified by PIX_EN)

Behaviour:
- One clock, CLK; RST is asynchronous, active high. On RST: hcnt=vcnt=0, RAM_ADDR=0, VGA_R/G/B=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, FRAME_CNT=0, FRAME_START=0, latched sprite position=0, pipeline cleared to blank. Reset mid-frame restarts at pixel (0,0) on the first PIX_EN after release.
- HMAX=HACT+HFP+HSYNC+HBP, VMAX=VACT+VFP+VSYNC+VBP. hcnt wraps HMAX-1 -> 0; vcnt increments on hcnt wrap and wraps VMAX-1 -> 0.
- HS asserted for hcnt in [HACT+HFP, HACT+HFP+HSYNC). VS asserted for vcnt in [VACT+VFP, VACT+VFP+VSYNC). Active region: hcnt<HACT and vcnt<VACT.
- Frame wrap: the strobe where hcnt=HMAX-1 and vcnt=VMAX-1. On it:
  - SPR_X/SPR_Y are latched (mid-frame changes are ignored).
  - FRAME_CNT increments, FRAME_MOD-1 -> 0.
  - FRAME_START pulses.
- Sprite window: hcnt in [sx, sx+SPR_W<<SCALE_LOG2) and vcnt in [sy, sy+SPR_H<<SCALE_LOG2), ANDed with the active region. Window bounds are computed at 11 bits, so no wrap at 1023.
- Address generation uses no multiplier:
  - row_base is cleared at frame wrap.
  - col resets to 0 at each hcnt wrap.
  - col advances one texel per 2^SCALE_LOG2 in-window pixels.
  - row_base += SPR_W after every 2^SCALE_LOG2 window lines, including lines with no visible pixels.
  - RAM_ADDR = row_base + col, registered.
- Clipping: a sprite extending past HACT or VACT is clipped. Because of the row_base rule, texels on later rows keep their correct addresses. If sx >= HACT or sy >= VACT, no sprite pixel is drawn.
- Pipeline: the colour decision for a given (hcnt,vcnt) appears on the VGA pins exactly PIPE=RD_LAT+2 strobes later. HS, VS and the window/active flags are delayed by the same PIPE so that colour and sync stay aligned.
- Colour selection:
  - Blanking (outside active region): 0.
  - In window, with KEY_EN=1 and RAM_Q==KEY_COLOR: BG_COLOR.
  - In window otherwise: RAM_Q.
  - Active but outside window: BG_COLOR.
- BG_COLOR is sampled in the stage aligned with RAM_Q.
- PIX_EN low: all outputs hold.

Test Plan:
- Small timing (HACT=8,HFP=1,HSYNC=2,HBP=1,VACT=4,VFP=1,VSYNC=1,VBP=1), PIX_EN=1 constant -> VGA_HS low exactly on pipeline-delayed hcnt 9,10 each 12-pixel line; VGA_VS low for 1 line of each 7-line frame; FRAME_START every 84 strobes.
- SPR_W=SPR_H=2, SCALE_LOG2=0, SPR_X=3, SPR_Y=1, RAM_Q=addr-tagged model, BG=12'h00F -> line 1 pixels 3,4 show texels 0,1; line 2 pixels 3,4 show texels 2,3; all other active pixels show 00F; blanking shows 000.
- SCALE_LOG2=1, same sprite -> each texel occupies a 2x2 block; RAM_ADDR sequence on line 1: 0,0,1,1; on lines 3/4: 2,2,3,3.
- SPR_X=7 (clipped at HACT=8) -> line 1 pixel 7 shows texel 0; the next line shows texel 2, not texel 1.
- KEY_EN=1, RAM returns KEY_COLOR for texel 1 -> that pixel shows BG_COLOR. Changing SPR_X mid-frame -> no effect until after FRAME_START.
- PIX_EN toggling every other CLK with RD_LAT=1 -> same pixel stream as the constant-enable case at half rate. Assert RST mid-line -> all outputs at reset values immediately; after release, the first frame is correctly timed; FRAME_CNT reaches FRAME_MOD-1 and wraps to 0.
